// File: rtl/bloom_load_ctrl.sv
// bloom_load_ctrl: clear/load sequencer and lookup-result aligner for the
// 16-way bloom-filter hash checker.
// Optional feature macro: BLOOM_HIT_CNT_EN adds a saturating hit_count output.
module bloom_load_ctrl #(
    parameter int unsigned LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_clear,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        wr_en,
    output logic        zwr_en,
    output logic [31:0] in_val,
    output logic [8:0]  in_addr,
    output logic [3:0]  filter_id,
    output logic        hash_ready,
    input  logic        a_valid,
    input  logic        b_valid,
    input  logic        a_hit,
    input  logic        b_hit,
    output logic        a_match,
    output logic        b_match,
    output logic        a_match_vld,
    output logic        b_match_vld,
    output logic        busy,
`ifdef BLOOM_HIT_CNT_EN
    output logic [31:0] hit_count,
`endif
    output logic        armed
);

    localparam int unsigned CNT_W  = 13;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 9;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(8191);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_ARMED = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                armed_n;
    logic                wr_en_n, zwr_en_n, ld_ready_n;
    logic [CNT_W-1:0]    waddr, waddr_n;
    logic [DATA_W-1:0]   in_val_n;
    logic                ld_hs;

    logic [LAT-1:0]      a_vld_sr, a_arm_sr;
    logic [LAT-1:0]      b_vld_sr, b_arm_sr;
    logic                a_acc, b_acc;

    assign filter_id = waddr[CNT_W-1:ADDR_W];
    assign in_addr   = waddr[ADDR_W-1:0];
    assign ld_hs     = ld_valid & ld_ready;

    // Next-state, counter and registered RAM-side output decode
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        armed_n    = armed;
        wr_en_n    = 1'b0;
        zwr_en_n   = 1'b0;
        waddr_n    = waddr;
        in_val_n   = in_val;
        ld_ready_n = 1'b0;
        if (cmd_clear) begin
            // Restart from word 0 regardless of current phase
            state_n  = S_CLEAR;
            cnt_n    = '0;
            armed_n  = 1'b0;
            zwr_en_n = 1'b1;
            waddr_n  = '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (cnt == CNT_MAX) begin
                        state_n = S_LOAD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n    = cnt + CNT_W'(1);
                        zwr_en_n = 1'b1;
                        waddr_n  = cnt + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    if (ld_hs) begin
                        wr_en_n  = 1'b1;
                        waddr_n  = cnt;
                        in_val_n = ld_data;
                        if (ld_last || (cnt == CNT_MAX)) begin
                            state_n = S_ARMED;
                            armed_n = 1'b1;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        ld_ready_n = (state_n == S_LOAD);
    end

    // State, counter and RAM-side output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            armed    <= 1'b0;
            wr_en    <= 1'b0;
            zwr_en   <= 1'b0;
            waddr    <= '0;
            in_val   <= '0;
            ld_ready <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            armed    <= armed_n;
            wr_en    <= wr_en_n;
            zwr_en   <= zwr_en_n;
            waddr    <= waddr_n;
            in_val   <= in_val_n;
            ld_ready <= ld_ready_n;
        end
    end

    // Lookups only while the checker address muxes are free
    assign hash_ready = ((state == S_IDLE) || (state == S_ARMED)) &
                        ~wr_en & ~zwr_en & ~cmd_clear;
    assign busy       = (state == S_CLEAR) || (state == S_LOAD);

    assign a_acc = a_valid & hash_ready;
    assign b_acc = b_valid & hash_ready;

    // Per-port valid/armed tags that track the checker's lookup latency
    always_ff @(posedge clk) begin
        if (rst || cmd_clear) begin
            a_vld_sr <= '0;
            a_arm_sr <= '0;
            b_vld_sr <= '0;
            b_arm_sr <= '0;
        end else begin
            a_vld_sr[0] <= a_acc;
            a_arm_sr[0] <= armed;
            b_vld_sr[0] <= b_acc;
            b_arm_sr[0] <= armed;
            for (int i = 1; i < int'(LAT); i++) begin
                a_vld_sr[i] <= a_vld_sr[i-1];
                a_arm_sr[i] <= a_arm_sr[i-1];
                b_vld_sr[i] <= b_vld_sr[i-1];
                b_arm_sr[i] <= b_arm_sr[i-1];
            end
        end
    end

    // Qualify the checker's hit with the tag leaving the pipeline
    assign a_match_vld = a_vld_sr[LAT-1];
    assign b_match_vld = b_vld_sr[LAT-1];
    assign a_match     = a_vld_sr[LAT-1] & a_arm_sr[LAT-1] & a_hit;
    assign b_match     = b_vld_sr[LAT-1] & b_arm_sr[LAT-1] & b_hit;

`ifdef BLOOM_HIT_CNT_EN
    logic [DATA_W:0] hit_sum;

    assign hit_sum = {1'b0, hit_count} + (DATA_W+1)'(a_match) + (DATA_W+1)'(b_match);

    // Saturating count of qualified matches since reset or clear
    always_ff @(posedge clk) begin
        if (rst || cmd_clear) begin
            hit_count <= '0;
        end else if (hit_sum[DATA_W]) begin
            hit_count <= '1;
        end else begin
            hit_count <= hit_sum[DATA_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_bloom_load_ctrl.sv
// Directed bench for bloom_load_ctrl: clear sweep, full and partial loads,
// abort/restart, reset mid-clear, lookup alignment and flush.
module tb_bloom_load_ctrl;

    localparam int unsigned LAT    = 3;
    localparam int          NWORDS = 8192;

    logic        clk = 1'b0;
    logic        rst, cmd_clear, ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        ld_ready, wr_en, zwr_en, hash_ready, busy, armed;
    logic [31:0] in_val;
    logic [8:0]  in_addr;
    logic [3:0]  filter_id;
    logic        a_valid, b_valid, a_hit, b_hit;
    logic        a_match, b_match, a_match_vld, b_match_vld;
    logic [12:0] waddr;
`ifdef BLOOM_HIT_CNT_EN
    logic [31:0] hit_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    assign waddr = {filter_id, in_addr};

    always #5 clk = ~clk;

    bloom_load_ctrl #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst), .cmd_clear(cmd_clear),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .wr_en(wr_en), .zwr_en(zwr_en), .in_val(in_val), .in_addr(in_addr),
        .filter_id(filter_id), .hash_ready(hash_ready),
        .a_valid(a_valid), .b_valid(b_valid), .a_hit(a_hit), .b_hit(b_hit),
        .a_match(a_match), .b_match(b_match),
        .a_match_vld(a_match_vld), .b_match_vld(b_match_vld),
        .busy(busy),
`ifdef BLOOM_HIT_CNT_EN
        .hit_count(hit_count),
`endif
        .armed(armed)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse cmd_clear now and follow n_cyc cycles of the sweep
    task automatic do_clear(input int n_cyc, input bit full);
        int e_addr, e_ctl, e_vld;
        e_addr = 0; e_ctl = 0; e_vld = 0;
        cmd_clear = 1'b1;
        ld_valid  = 1'b1;
        ld_data   = 32'hDEAD_BEEF;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        #1;
        chk("clr_cmd_hash_ready", 32'(hash_ready), 0);
        tick;
        cmd_clear = 1'b0;
        for (int i = 0; i < n_cyc; i++) begin
            #1;
            if (zwr_en !== 1'b1 || waddr !== 13'(i)) e_addr++;
            if (busy !== 1'b1 || hash_ready !== 1'b0 || ld_ready !== 1'b0 ||
                wr_en !== 1'b0 || armed !== 1'b0) e_ctl++;
            if (a_match_vld !== 1'b0 || b_match_vld !== 1'b0) e_vld++;
            tick;
        end
        chk("clr_addr_seq", 32'(e_addr), 0);
        chk("clr_ctrl", 32'(e_ctl), 0);
        chk("clr_no_result", 32'(e_vld), 0);
        ld_valid = 1'b0;
        if (full) begin
            #1;
            chk("clr_end_zwr", 32'(zwr_en), 0);
            chk("clr_end_ld_ready", 32'(ld_ready), 1);
            chk("clr_end_busy", 32'(busy), 1);
        end
    endtask

    initial begin
        int e1, e2, e3, idx, nwr;
        bit exp_wr, done;
        logic [31:0] exp_data;
        logic [12:0] exp_addr;

        rst = 1'b1; cmd_clear = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        a_valid = 1'b0; b_valid = 1'b0; a_hit = 1'b0; b_hit = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_hash_ready", 32'(hash_ready), 1);
        chk("rst_outs", {wr_en, zwr_en, ld_ready, busy, armed, a_match_vld, b_match_vld, a_match, b_match}, 0);
        chk("rst_addr", 32'(waddr), 0);
        chk("rst_in_val", in_val, 0);
`ifdef BLOOM_HIT_CNT_EN
        chk("rst_hit_count", hit_count, 0);
`endif

        // Lookup issued while unarmed returns a strobe with no match
        a_hit = 1'b1;
        for (int k = 0; k <= int'(LAT) + 1; k++) begin
            a_valid = (k == 0);
            #1;
            chk($sformatf("idle_vld_k%0d", k), 32'(a_match_vld), 32'(k == int'(LAT)));
            chk($sformatf("idle_match_k%0d", k), 32'(a_match), 0);
            tick;
        end
        a_valid = 1'b0;

        do_clear(NWORDS, 1'b1);

        // Full 8192-word image terminated by the counter
        e1 = 0; e2 = 0; e3 = 0;
        for (int i = 0; i < NWORDS; i++) begin
            ld_valid = 1'b1; ld_data = 32'(i); ld_last = 1'b0;
            #1;
            if (ld_ready !== 1'b1) e1++;
            if (i == 0) begin
                if (wr_en !== 1'b0) e2++;
            end else if (wr_en !== 1'b1 || in_val !== 32'(i - 1) || waddr !== 13'(i - 1)) e2++;
            if (armed !== 1'b0 || hash_ready !== 1'b0 || zwr_en !== 1'b0) e3++;
            tick;
        end
        ld_valid = 1'b0;
        #1;
        chk("full_ready", 32'(e1), 0);
        chk("full_writes", 32'(e2), 0);
        chk("full_ctrl", 32'(e3), 0);
        chk("full_last_wr", 32'(wr_en), 1);
        chk("full_last_data", in_val, 32'd8191);
        chk("full_last_addr", 32'(waddr), 32'd8191);
        chk("full_armed", 32'(armed), 1);
        chk("full_hash_ready_pend", 32'(hash_ready), 0);
        chk("full_busy", 32'(busy), 0);
        chk("full_ld_ready", 32'(ld_ready), 0);
        tick;
        #1;
        chk("full_hash_ready", 32'(hash_ready), 1);
        chk("full_wr_done", 32'(wr_en), 0);

        // Back-to-back armed lookups return exactly LAT cycles later
        a_hit = 1'b1;
        for (int k = 0; k <= int'(LAT) + 6; k++) begin
            a_valid = (k < 5);
            #1;
            chk($sformatf("arm_vld_k%0d", k), 32'(a_match_vld), 32'(k >= int'(LAT) && k < int'(LAT) + 5));
            chk($sformatf("arm_match_k%0d", k), 32'(a_match), 32'(k >= int'(LAT) && k < int'(LAT) + 5));
            tick;
        end
        a_valid = 1'b0;

        // In-flight lookups are dropped by a clear; then reset mid-clear
        b_hit = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            tick;
        end
        do_clear(20, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("rstmid_outs", {busy, armed, zwr_en, wr_en, ld_ready, a_match_vld, b_match_vld}, 0);
        chk("rstmid_hash_ready", 32'(hash_ready), 1);

        // Clear restarted while clearing
        do_clear(30, 1'b0);
        do_clear(NWORDS, 1'b1);

        // Load aborted by a clear after 10 words
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1; ld_data = 32'h5500_0000 + 32'(i);
            tick;
        end
        #1;
        chk("abort_busy", 32'(busy), 1);
        chk("abort_armed", 32'(armed), 0);
        do_clear(NWORDS, 1'b1);

        // Short image: 100 words plus a last word, with idle gaps
        idx = 0; nwr = 0; done = 1'b0; exp_wr = 1'b0; exp_data = '0; exp_addr = '0; e1 = 0;
        for (int j = 0; j < 300 && !done; j++) begin
            ld_valid = ((j % 5) != 4);
            ld_data  = 32'hA500_0000 + 32'(idx);
            ld_last  = (idx == 100);
            #1;
            if (wr_en !== exp_wr || ld_ready !== 1'b1) e1++;
            if (exp_wr && (in_val !== exp_data || waddr !== exp_addr)) e1++;
            if (wr_en === 1'b1) nwr++;
            exp_wr   = ld_valid;
            exp_data = ld_data;
            exp_addr = 13'(idx);
            if (ld_valid) begin
                if (ld_last) done = 1'b1;
                idx++;
            end
            tick;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        chk("part_done", 32'(done), 1);
        chk("part_stream", 32'(e1), 0);
        chk("part_writes", 32'(nwr) + 32'(wr_en), 101);
        chk("part_last_fid", 32'(filter_id), 0);
        chk("part_last_addr", 32'(in_addr), 100);
        chk("part_last_data", in_val, 32'hA500_0064);
        chk("part_armed", 32'(armed), 1);
        chk("part_hash_ready_pend", 32'(hash_ready), 0);
        tick;
        #1;
        chk("part_hash_ready", 32'(hash_ready), 1);
        chk("part_busy", 32'(busy), 0);

`ifdef BLOOM_HIT_CNT_EN
        chk("cnt_start", hit_count, 0);
        a_hit = 1'b1; b_hit = 1'b1;
        for (int k = 0; k <= int'(LAT) + 10; k++) begin
            a_valid = (k < 10); b_valid = (k < 10);
            tick;
        end
        #1;
        chk("cnt_20", hit_count, 32'd20);
`endif

        // Both ports armed: hit qualifies, miss strobes with match=0
        a_valid = 1'b1; b_valid = 1'b1;
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        for (int k = 1; k < int'(LAT); k++) tick;
        a_hit = 1'b1; b_hit = 1'b0;
        #1;
        chk("ab_a_vld", 32'(a_match_vld), 1);
        chk("ab_a_match", 32'(a_match), 1);
        chk("ab_b_vld", 32'(b_match_vld), 1);
        chk("ab_b_miss", 32'(b_match), 0);
        b_hit = 1'b1;
        #1;
        chk("ab_b_hit", 32'(b_match), 1);
        tick;
        #1;
        chk("ab_after", {a_match_vld, b_match_vld}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
